mac_seq_ctrl: RTL and testbench

//  Sequencer for one 4-stage DSP MAC (2-stage operand/product path + accumulate + output reg).
//  - On start: streams LEN operand-pair read addresses into the A and B memories.
//  - Aligns mac_ld_acc and mac_inC to the first product of the run.
//  - Flags the cycle in which the MAC output holds the finished dot product.
//  - Memory read data feeds the MAC inA/inB directly, outside this block.
//  - Sits between the layer engine (start/result) and the MAC plus its operand memories.

---
 rtl/mac_seq_ctrl_pkg.sv | 15 +
 rtl/mac_seq_ctrl_tag_pipe.sv | 42 ++++
 rtl/mac_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants and types for the MAC sequencer: MAC pipeline depth,
// FSM state encoding and bit positions of the per-element tag flags.
package mac_seq_ctrl_pkg;

    localparam int MAC_LAT   = 4;
    localparam int TAG_FIRST = 0;
    localparam int TAG_LAST  = 1;
    localparam int TAG_FLAGS = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_tag_pipe.sv
// Shift line carrying per-element {first,last} flags with a tap per stage;
// the run's bias rides alongside the flags only as far as the stage that needs it.
module mac_tag_pipe
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DEPTH    = 5,
    parameter int BIAS_TAP = 0,
    parameter int BIAS_W   = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TAG_FLAGS-1:0]             flags_in,
    input  logic [BIAS_W-1:0]                bias_in,
    output logic [DEPTH-1:0][TAG_FLAGS-1:0]  flag_tap,
    output logic [BIAS_W-1:0]                bias_tap
);

    logic [TAG_FLAGS-1:0] flag_reg [DEPTH];
    logic [BIAS_W-1:0]    bias_reg [BIAS_TAP+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) flag_reg[i] <= '0;
            for (int i = 0; i <= BIAS_TAP; i++) bias_reg[i] <= '0;
        end else begin
            flag_reg[0] <= flags_in;
            for (int i = 1; i < DEPTH; i++) flag_reg[i] <= flag_reg[i-1];
            bias_reg[0] <= bias_in;
            for (int i = 1; i <= BIAS_TAP; i++) bias_reg[i] <= bias_reg[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign flag_tap[gi] = flag_reg[gi];
        end
    endgenerate

    assign bias_tap = bias_reg[BIAS_TAP];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 4-stage MAC: issues operand addresses, aligns ld_acc/inC
// to the first product of each run and captures the finished dot product.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    input  logic [LEN_W-1:0]    len,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    input  logic [ADDR_W-1:0]   stride_a,
    input  logic [ADDR_W-1:0]   stride_b,
    input  logic                bias_en,
    input  logic [2*DATA_W-1:0] bias,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]   addr_b,
    output logic                mac_ld_acc,
    output logic [2*DATA_W-1:0] mac_inC,
    input  logic [2*DATA_W-1:0] mac_out,
    output logic [2*DATA_W-1:0] result,
    output logic                result_valid,
    output logic                len_err,
    output logic                busy
);

    localparam int ACC_W     = 2 * DATA_W;
    localparam int TAG_DEPTH = MEM_LAT + MAC_LAT;
    // inC is registered, so it loads one stage before the first operands reach the MAC
    localparam int TAP_INC   = MEM_LAT - 1;
    localparam int TAP_LD    = MEM_LAT + 1;
    localparam int TAP_RES   = MEM_LAT + 3;

    state_t              state_reg, state_next;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_a_reg, addr_a_next;
    logic [ADDR_W-1:0]   addr_b_reg, addr_b_next;
    logic [ADDR_W-1:0]   stride_a_reg, stride_a_next;
    logic [ADDR_W-1:0]   stride_b_reg, stride_b_next;
    logic [ACC_W-1:0]    bias_reg, bias_next;
    logic                first_reg, first_next;
    logic                last_issue;
    logic                accept;
    logic                zero_start;

    logic [ACC_W-1:0]    mac_inc_reg;
    logic [ACC_W-1:0]    result_reg;
    logic                result_valid_reg;
    logic                len_err_reg;

    logic [TAG_FLAGS-1:0]                tag_in;
    logic [TAG_DEPTH-1:0][TAG_FLAGS-1:0] flag_tap;
    logic [ACC_W-1:0]                    bias_tap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_a_reg   <= '0;
            addr_b_reg   <= '0;
            stride_a_reg <= '0;
            stride_b_reg <= '0;
            bias_reg     <= '0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_a_reg   <= addr_a_next;
            addr_b_reg   <= addr_b_next;
            stride_a_reg <= stride_a_next;
            stride_b_reg <= stride_b_next;
            bias_reg     <= bias_next;
            first_reg    <= first_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_a_next   = addr_a_reg;
        addr_b_next   = addr_b_reg;
        stride_a_next = stride_a_reg;
        stride_b_next = stride_b_reg;
        bias_next     = bias_reg;
        first_next    = first_reg;
        last_issue    = (state_reg == ST_ISSUE) && (cnt_reg == LEN_W'(1));
        ready         = (state_reg == ST_IDLE) || last_issue;
        mem_en        = (state_reg == ST_ISSUE);
        accept        = start && ready && (len != '0);
        zero_start    = start && ready && (len == '0);

        if (state_reg == ST_ISSUE) begin
            cnt_next    = cnt_reg - LEN_W'(1);
            addr_a_next = addr_a_reg + stride_a_reg;
            addr_b_next = addr_b_reg + stride_b_reg;
            first_next  = 1'b0;
            if (last_issue) state_next = ST_IDLE;
        end

        // A new run accepted in the final issue cycle overrides the wind-down above
        if (accept) begin
            state_next    = ST_ISSUE;
            cnt_next      = len;
            addr_a_next   = base_a;
            addr_b_next   = base_b;
            stride_a_next = stride_a;
            stride_b_next = stride_b;
            bias_next     = bias_en ? bias : '0;
            first_next    = 1'b1;
        end
    end

    always_comb begin
        tag_in            = '0;
        tag_in[TAG_FIRST] = mem_en && first_reg;
        tag_in[TAG_LAST]  = last_issue;
    end

    mac_tag_pipe #(
        .DEPTH    (TAG_DEPTH),
        .BIAS_TAP (TAP_INC),
        .BIAS_W   (ACC_W)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flags_in (tag_in),
        .bias_in  (bias_reg),
        .flag_tap (flag_tap),
        .bias_tap (bias_tap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_inc_reg      <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            len_err_reg      <= 1'b0;
        end else begin
            if (flag_tap[TAP_INC][TAG_FIRST]) mac_inc_reg <= bias_tap;
            if (flag_tap[TAP_RES][TAG_LAST])  result_reg  <= mac_out;
            result_valid_reg <= flag_tap[TAP_RES][TAG_LAST];
            len_err_reg      <= zero_start;
        end
    end

    assign addr_a       = addr_a_reg;
    assign addr_b       = addr_b_reg;
    assign mac_ld_acc   = flag_tap[TAP_LD][TAG_FIRST];
    assign mac_inC      = mac_inc_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign len_err      = len_err_reg;
    assign busy         = (state_reg == ST_ISSUE) || (|flag_tap) || result_valid_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: models 1-cycle operand RAMs and a 4-stage MAC,
// predicts every output per cycle from the run-level rules.
module tb_mac_seq_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 10;
    localparam int MEM_LAT = 1;
    localparam int ACC_W   = 32;
    localparam int NCYC    = 8192;
    localparam int MSIZE   = 1 << ADDR_W;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               ready;
    logic [LEN_W-1:0]   len;
    logic [ADDR_W-1:0]  base_a, base_b, stride_a, stride_b;
    logic               bias_en;
    logic [ACC_W-1:0]   bias;
    logic               mem_en;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic               mac_ld_acc;
    logic [ACC_W-1:0]   mac_inC;
    logic [ACC_W-1:0]   mac_out;
    logic [ACC_W-1:0]   result;
    logic               result_valid;
    logic               len_err;
    logic               busy;

    mac_seq_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .len(len),
        .base_a(base_a), .base_b(base_b), .stride_a(stride_a), .stride_b(stride_b),
        .bias_en(bias_en), .bias(bias), .mem_en(mem_en), .addr_a(addr_a),
        .addr_b(addr_b), .mac_ld_acc(mac_ld_acc), .mac_inC(mac_inC),
        .mac_out(mac_out), .result(result), .result_valid(result_valid),
        .len_err(len_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: synchronous operand RAMs and the 4-stage MAC
    logic signed [DATA_W-1:0] mem_a [MSIZE];
    logic signed [DATA_W-1:0] mem_b [MSIZE];
    logic signed [DATA_W-1:0] rd_a, rd_b, a_r, b_r;
    logic signed [ACC_W-1:0]  p_r, c_r, acc_r, out_r;

    always @(posedge clk) begin
        if (mem_en) begin
            rd_a <= mem_a[addr_a];
            rd_b <= mem_b[addr_b];
        end
        a_r   <= rd_a;
        b_r   <= rd_b;
        p_r   <= a_r * b_r;
        c_r   <= mac_inC;
        acc_r <= mac_ld_acc ? (c_r + p_r) : (acc_r + p_r);
        out_r <= acc_r;
    end
    assign mac_out = out_r;

    // Per-cycle expectations derived from each accepted run
    bit               exp_men  [NCYC];
    logic [ADDR_W-1:0] exp_aa  [NCYC];
    logic [ADDR_W-1:0] exp_ab  [NCYC];
    bit               exp_ld   [NCYC];
    bit               exp_lerr [NCYC];
    bit               exp_rv   [NCYC];
    logic [ACC_W-1:0] exp_res  [NCYC];
    bit               inc_v    [NCYC];
    logic [ACC_W-1:0] inc_val  [NCYC];
    int               exp_busy [NCYC];   // 0, 1, or 2 = not checked

    int               cyc = 0;
    int               issue_end = 0;
    logic [ACC_W-1:0] hold_res = '0;
    logic [ACC_W-1:0] hold_inc = '0;
    int               tests = 0;
    int               fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_from(input int c0);
        for (int t = c0; t < NCYC; t++) begin
            exp_men[t] = 0; exp_ld[t] = 0; exp_lerr[t] = 0; exp_rv[t] = 0;
            inc_v[t] = 0; exp_busy[t] = 0;
        end
    endtask

    task automatic tick();
        bit rst_at_edge;
        rst_at_edge = !rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NCYC - 64) begin
            $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, NCYC - 64);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst_at_edge) begin
            clear_from(cyc);
            hold_res  = '0;
            hold_inc  = '0;
            issue_end = 0;
        end
        if (inc_v[cyc])  hold_inc = inc_val[cyc];
        if (exp_rv[cyc]) hold_res = exp_res[cyc];
        chk("mem_en", mem_en, exp_men[cyc]);
        if (exp_men[cyc]) begin
            chk("addr_a", addr_a, exp_aa[cyc]);
            chk("addr_b", addr_b, exp_ab[cyc]);
        end
        chk("ready", ready, (cyc >= issue_end));
        chk("mac_ld_acc", mac_ld_acc, exp_ld[cyc]);
        chk("mac_inC", mac_inC, hold_inc);
        chk("len_err", len_err, exp_lerr[cyc]);
        chk("result_valid", result_valid, exp_rv[cyc]);
        chk("result", result, hold_res);
        if (exp_busy[cyc] != 2) chk("busy", busy, exp_busy[cyc]);
        if (exp_rv[cyc])
            $display("[TB] cycle %0d result=%0d expected=%0d", cyc,
                     $signed(result), $signed(hold_res));
    endtask

    task automatic start_run(input int n, input int ba, input int bb, input int sa,
                             input int sb, input bit ben, input logic [ACC_W-1:0] bv);
        int s, rvc, ia, ib;
        logic signed [ACC_W-1:0] sum, pa, pb;
        start    = 1'b1;
        len      = LEN_W'(n);
        base_a   = ADDR_W'(ba);
        base_b   = ADDR_W'(bb);
        stride_a = ADDR_W'(sa);
        stride_b = ADDR_W'(sb);
        bias_en  = ben;
        bias     = bv;
        if (n == 0) begin
            exp_lerr[cyc + 1] = 1;
            $display("[TB] cycle %0d start len=0 (rejected)", cyc);
        end else begin
            s   = cyc + 1;
            sum = ben ? $signed(bv) : '0;
            for (int k = 0; k < n; k++) begin
                ia = (ba + k * sa) % MSIZE;
                ib = (bb + k * sb) % MSIZE;
                exp_men[s + k] = 1;
                exp_aa[s + k]  = ADDR_W'(ia);
                exp_ab[s + k]  = ADDR_W'(ib);
                pa  = mem_a[ia];
                pb  = mem_b[ib];
                sum = sum + pa * pb;
            end
            exp_ld[s + MEM_LAT + 2]  = 1;
            inc_v[s + MEM_LAT + 1]   = 1;
            inc_val[s + MEM_LAT + 1] = ben ? bv : '0;
            rvc = s + n + MEM_LAT + 4;
            exp_rv[rvc]  = 1;
            exp_res[rvc] = sum;
            for (int t = s; t < rvc; t++) exp_busy[t] = 1;
            if (exp_busy[rvc] != 1) exp_busy[rvc] = 2;
            issue_end = s + n - 1;
            $display("[TB] cycle %0d start len=%0d base_a=%0d base_b=%0d bias=%0d", cyc, n,
                     ba, bb, ben ? $signed(bv) : 0);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_addr_a", addr_a, '0);
        chk("rst_addr_b", addr_b, '0);
        chk("rst_ld_acc", mac_ld_acc, 1'b0);
        chk("rst_inC", mac_inC, '0);
        chk("rst_result", result, '0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0;
        stride_a = '0; stride_b = '0; bias_en = 1'b0; bias = '0;
        clear_from(0);
        for (int i = 0; i < MSIZE; i++) begin
            mem_a[i] = DATA_W'($urandom);
            mem_b[i] = DATA_W'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DATA_W'(i + 1);
            mem_b[i] = DATA_W'(i + 5);
        end
        mem_a[200] = 16'sd3; mem_b[200] = 16'sd4;
        mem_a[100] = 16'sd1; mem_a[101] = 16'sd2;
        mem_b[100] = 16'sd1; mem_b[101] = 16'sd2;

        idle(2);
        check_reset_values();
        rst_n = 1'b1;
        idle(2);

        // Plain dot product, then with negative bias
        start_run(4, 0, 0, 1, 1, 1'b0, 32'd0);
        idle(14);
        start_run(4, 0, 0, 1, 1, 1'b1, 32'hFFFF_FF9C);
        idle(14);

        // Address wrap
        start_run(3, 1020, 0, 3, 1, 1'b0, 32'd0);
        idle(12);

        // Back-to-back runs, first of length 1
        start_run(1, 200, 200, 1, 1, 1'b1, 32'd7);
        start_run(2, 100, 100, 1, 1, 1'b0, 32'd0);
        idle(14);

        // Zero-length request
        start_run(0, 0, 0, 1, 1, 1'b1, 32'd5);
        idle(12);

        // Reset during cycle s+2 of a len=8 run, then a clean run
        start_run(8, 0, 0, 1, 1, 1'b1, 32'd11);
        idle(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values();
        idle(20);
        start_run(4, 0, 0, 1, 1, 1'b0, 32'd0);
        idle(14);

        // Randomised runs with gaps of 0..2 cycles after ready
        for (int r = 0; r < 120; r++) begin
            while (cyc < issue_end) tick();
            idle($urandom_range(0, 2));
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            start_run(n, $urandom_range(0, MSIZE - 1), $urandom_range(0, MSIZE - 1),
                      $urandom_range(0, MSIZE - 1), $urandom_range(0, MSIZE - 1),
                      1'($urandom_range(0, 1)), $urandom);
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
